rbm_sequencer: RTL and testbench
================================

Name: rbm_sequencer

Overview:
- Synthesizable controller that sequences the RBM inference datapath `Main`; replaces bench-level sequencing.
- Each iteration runs two phases:
  - Hidden phase: per neuron, every visible pixel term, then the bias term, then capture of the hidden bit.
  - Classifier phase: per class, every hidden term, then the bias term, then accumulation of the spike.
- Repeats for N_ITER iterations, then reports per-class spike counts and the argmax class.
- Weight/bias memories are external, asynchronous-read, and addressed by this block.

Parameters:
N_VIS, 784, visible pixels per image
N_HID, 441, hidden neurons
N_CLS, 10, output classes
N_ITER, 30, stochastic iterations per inference
VIS_AW, 10, width of vis_addr (must hold N_VIS)
HID_AW, 9, width of hid_addr (must hold N_HID)
CLS_AW, 4, width of cls_addr/result
CNT_W, 5, per-class counter width (must hold N_ITER)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin inference; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; class_count/result valid from this cycle until next start
vis_addr  out  VIS_AW  pixel index; equals N_VIS during hidden bias cycle
hid_addr  out  HID_AW  hidden index; equals N_HID during classifier bias cycle
cls_addr  out  CLS_AW  current class
sel_bias  out  1  high in bias cycles; external mux selects bias memory
pixel_in  in  1  image bit at vis_addr (same-cycle read)
pixel  out  1  pixel_in in hidden term cycles; 1 in hidden bias cycle; else 0
enable_hidden  out  1  high throughout hidden phase
enable_classi  out  1  high throughout classifier phase
hidden_in  in  1  datapath hidden result
hidden_pixel  out  1  stored hidden bit [hid_addr] in classifier term cycles; 1 in bias cycle; else 0
spike_in  in  1  datapath spike result
class_count  out  N_CLS*CNT_W  flattened spike counts; class k at bits [k*CNT_W +: CNT_W]
result  out  CLS_AW  argmax class

Behaviour:
- Reset (async, any state):
  - All outputs 0; state IDLE; counters and hidden store cleared.
  - A reset asserted mid-inference aborts it; no done pulse.
- FSM states: IDLE, H_TERM, H_BIAS, H_CAPT, C_TERM, C_BIAS, C_CAPT, ARGMAX, DONE.
- IDLE:
  - start=1 → H_TERM.
  - Clears all class counts, iteration counter = 0, vis_addr = hid_addr = cls_addr = 0.
  - start in any other state is ignored.
- Hidden phase:
  - H_TERM: one cycle per vis_addr 0..N_VIS-1, incrementing each cycle. After N_VIS-1 → H_BIAS (vis_addr = N_VIS).
  - H_BIAS: one cycle → H_CAPT.
  - H_CAPT: store hidden_in into hidden bit [hid_addr].
    - If hid_addr < N_HID-1: hid_addr+1, vis_addr = 0, → H_TERM.
    - Else: hid_addr = 0, cls_addr = 0, → C_TERM.
- Classifier phase:
  - C_TERM: one cycle per hid_addr 0..N_HID-1 → C_BIAS (hid_addr = N_HID).
  - C_BIAS: one cycle → C_CAPT.
  - C_CAPT: count[cls_addr] += spike_in.
    - If cls_addr < N_CLS-1: cls_addr+1, hid_addr = 0, → C_TERM.
    - Else: iteration+1. If iteration == N_ITER, → ARGMAX; otherwise restart at H_TERM with all addresses 0.
- Cycle counts:
  - Per neuron: N_VIS+2 cycles.
  - Per class: N_HID+2 cycles.
  - Per iteration: N_HID*(N_VIS+2) + N_CLS*(N_HID+2) cycles.
- Hidden store:
  - Holds the current iteration's values only; each iteration overwrites it.
  - Classifier phase reads only bits written in the same iteration.
- ARGMAX:
  - Scans classes 0..N_CLS-1 over N_CLS cycles with strict greater-than compare, so ties resolve to the lowest index.
  - Then DONE for one cycle (done=1, busy=0) → IDLE.
- Latency:
  - Start-accept cycle = 0; first H_TERM = cycle 1.
  - done in cycle N_ITER*(per iteration) + N_CLS + 1.
- Counts never overflow by construction, since CNT_W ≥ log2(N_ITER+1).
- Phase isolation: enable_hidden and enable_classi are never high together; both are 0 in IDLE, ARGMAX and DONE.
- Output stability: class_count and result hold after done until the next accepted start clears the counts.

Test Plan:
All scenarios use N_VIS=4, N_HID=3, N_CLS=2, N_ITER=2, CNT_W=2, with pixel_in tied 1.
1. Start with spike_in=1 only in cls 1 capture cycles → done at cycle 59; class_count = {2,0} (class1=2, class0=0); result=1; busy high cycles 1..58.
2. Drive hidden_in = 1,0,1 for neurons 0..2 → during C_TERM, hidden_pixel = 1,0,1 for hid_addr 0..2, and =1 in C_BIAS; sequence vis_addr 0,1,2,3,4 repeats per neuron with pixel=1 at addr 4.
3. spike_in=1 in every capture → counts {2,2}; result=0 (tie → lowest).
4. Pulse start again at cycle 10 mid-run → ignored; done still at cycle 59, only once.
5. Assert reset at cycle 20 → same-cycle outputs 0, busy=0, no done; new start afterwards completes normally with counts cleared.
6. Check per cycle that enable_hidden and enable_classi are never both 1, and sel_bias is high only when vis_addr=4 (hidden phase) or hid_addr=3 (classifier phase).

Source files
------------

// File: rtl/rbm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rbm_sequencer
//  Purpose  : Cycle-level controller for the RBM inference datapath. Walks
//             hidden neurons (visible terms, bias, capture), then output
//             classes (hidden terms, bias, spike accumulation), repeats for
//             N_ITER iterations, then picks the class with the most spikes.
//  Revision : 1.0 - initial release
// ============================================================================
module rbm_sequencer #(
    parameter int N_VIS  = 784,
    parameter int N_HID  = 441,
    parameter int N_CLS  = 10,
    parameter int N_ITER = 30,
    parameter int VIS_AW = 10,
    parameter int HID_AW = 9,
    parameter int CLS_AW = 4,
    parameter int CNT_W  = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [VIS_AW-1:0]        vis_addr,
    output logic [HID_AW-1:0]        hid_addr,
    output logic [CLS_AW-1:0]        cls_addr,
    output logic                     sel_bias,
    input  logic                     pixel_in,
    output logic                     pixel,
    output logic                     enable_hidden,
    output logic                     enable_classi,
    input  logic                     hidden_in,
    output logic                     hidden_pixel,
    input  logic                     spike_in,
    output logic [N_CLS*CNT_W-1:0]   class_count,
    output logic [CLS_AW-1:0]        result
);

    localparam int ITW = $clog2(N_ITER + 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_H_TERM = 4'd1;
    localparam logic [3:0] S_H_BIAS = 4'd2;
    localparam logic [3:0] S_H_CAPT = 4'd3;
    localparam logic [3:0] S_C_TERM = 4'd4;
    localparam logic [3:0] S_C_BIAS = 4'd5;
    localparam logic [3:0] S_C_CAPT = 4'd6;
    localparam logic [3:0] S_ARGMAX = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]               r_state;
    logic [3:0]               w_next;
    logic [VIS_AW-1:0]        r_vis;
    logic [HID_AW-1:0]        r_hid;
    logic [CLS_AW-1:0]        r_cls;
    logic [ITW-1:0]           r_iter;
    logic [CLS_AW-1:0]        r_scan;
    logic [CNT_W-1:0]         r_best_val;
    logic [CLS_AW-1:0]        r_best_idx;
    logic [N_HID-1:0]         r_hid_store;
    logic [N_CLS*CNT_W-1:0]   r_count;

    logic                     w_vis_last;
    logic                     w_hid_last;
    logic                     w_cls_last;
    logic                     w_iter_last;
    logic                     w_scan_last;
    logic                     w_hid_bit;
    logic [CNT_W-1:0]         w_scan_cnt;

    assign w_vis_last  = (r_vis  == VIS_AW'(N_VIS - 1));
    assign w_hid_last  = (r_hid  == HID_AW'(N_HID - 1));
    assign w_cls_last  = (r_cls  == CLS_AW'(N_CLS - 1));
    assign w_iter_last = (r_iter == ITW'(N_ITER - 1));
    assign w_scan_last = (r_scan == CLS_AW'(N_CLS - 1));

    // Read the stored hidden bit by compare-select so the bias address
    // (one past the last neuron) never indexes out of range.
    always_comb begin
        w_hid_bit = 1'b0;
        for (int k = 0; k < N_HID; k++) begin
            if (r_hid == HID_AW'(k)) begin
                w_hid_bit = r_hid_store[k];
            end
        end
    end

    // Count of the class currently examined by the argmax scan.
    always_comb begin
        w_scan_cnt = '0;
        for (int k = 0; k < N_CLS; k++) begin
            if (r_scan == CLS_AW'(k)) begin
                w_scan_cnt = r_count[k*CNT_W +: CNT_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_H_TERM;
            S_H_TERM: if (w_vis_last) w_next = S_H_BIAS;
            S_H_BIAS: w_next = S_H_CAPT;
            S_H_CAPT: w_next = w_hid_last ? S_C_TERM : S_H_TERM;
            S_C_TERM: if (w_hid_last) w_next = S_C_BIAS;
            S_C_BIAS: w_next = S_C_CAPT;
            S_C_CAPT: begin
                if (!w_cls_last)      w_next = S_C_TERM;
                else if (w_iter_last) w_next = S_ARGMAX;
                else                  w_next = S_H_TERM;
            end
            S_ARGMAX: if (w_scan_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode; addresses and results come straight from registers.
    always_comb begin
        busy          = (r_state != S_IDLE) && (r_state != S_DONE);
        done          = (r_state == S_DONE);
        sel_bias      = (r_state == S_H_BIAS) || (r_state == S_C_BIAS);
        enable_hidden = (r_state == S_H_TERM) || (r_state == S_H_BIAS) || (r_state == S_H_CAPT);
        enable_classi = (r_state == S_C_TERM) || (r_state == S_C_BIAS) || (r_state == S_C_CAPT);
        pixel         = 1'b0;
        hidden_pixel  = 1'b0;
        if (r_state == S_H_TERM) pixel = pixel_in;
        if (r_state == S_H_BIAS) pixel = 1'b1;
        if (r_state == S_C_TERM) hidden_pixel = w_hid_bit;
        if (r_state == S_C_BIAS) hidden_pixel = 1'b1;
        vis_addr      = r_vis;
        hid_addr      = r_hid;
        cls_addr      = r_cls;
        class_count   = r_count;
        result        = r_best_idx;
    end

    // Address walking, hidden store, spike counters and argmax scan.
    // Counts and result are cleared only on an accepted start so they
    // remain readable in IDLE after done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vis       <= '0;
            r_hid       <= '0;
            r_cls       <= '0;
            r_iter      <= '0;
            r_scan      <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_hid_store <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vis      <= '0;
                        r_hid      <= '0;
                        r_cls      <= '0;
                        r_iter     <= '0;
                        r_scan     <= '0;
                        r_best_val <= '0;
                        r_best_idx <= '0;
                        r_count    <= '0;
                    end
                end
                S_H_TERM: begin
                    r_vis <= r_vis + VIS_AW'(1);
                end
                S_H_CAPT: begin
                    for (int k = 0; k < N_HID; k++) begin
                        if (r_hid == HID_AW'(k)) begin
                            r_hid_store[k] <= hidden_in;
                        end
                    end
                    r_vis <= '0;
                    if (w_hid_last) begin
                        r_hid <= '0;
                        r_cls <= '0;
                    end else begin
                        r_hid <= r_hid + HID_AW'(1);
                    end
                end
                S_C_TERM: begin
                    r_hid <= r_hid + HID_AW'(1);
                end
                S_C_CAPT: begin
                    for (int k = 0; k < N_CLS; k++) begin
                        if (r_cls == CLS_AW'(k)) begin
                            r_count[k*CNT_W +: CNT_W] <= r_count[k*CNT_W +: CNT_W] + CNT_W'(spike_in);
                        end
                    end
                    r_hid <= '0;
                    if (w_cls_last) begin
                        r_cls  <= '0;
                        r_vis  <= '0;
                        r_iter <= r_iter + ITW'(1);
                        if (w_iter_last) begin
                            r_scan     <= '0;
                            r_best_val <= '0;
                            r_best_idx <= '0;
                        end
                    end else begin
                        r_cls <= r_cls + CLS_AW'(1);
                    end
                end
                S_ARGMAX: begin
                    // Strict compare keeps the lowest index on ties.
                    if (w_scan_cnt > r_best_val) begin
                        r_best_val <= w_scan_cnt;
                        r_best_idx <= r_scan;
                    end
                    r_scan <= r_scan + CLS_AW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rbm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rbm_sequencer
//  Purpose  : Directed self-checking bench for rbm_sequencer with a small
//             configuration; per-cycle address/strobe model plus a queue of
//             expected end-of-inference results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rbm_sequencer;

    localparam int N_VIS  = 4;
    localparam int N_HID  = 3;
    localparam int N_CLS  = 2;
    localparam int N_ITER = 2;
    localparam int VIS_AW = 3;
    localparam int HID_AW = 2;
    localparam int CLS_AW = 1;
    localparam int CNT_W  = 2;

    localparam int NEU_CYC  = N_VIS + 2;
    localparam int CLS_CYC  = N_HID + 2;
    localparam int HPH_CYC  = N_HID * NEU_CYC;
    localparam int ITER_CYC = HPH_CYC + N_CLS * CLS_CYC;
    localparam int RUN_CYC  = N_ITER * ITER_CYC;
    localparam int DONE_CYC = RUN_CYC + N_CLS + 1;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [VIS_AW-1:0]      vis_addr;
    logic [HID_AW-1:0]      hid_addr;
    logic [CLS_AW-1:0]      cls_addr;
    logic                   sel_bias;
    logic                   pixel_in;
    logic                   pixel;
    logic                   enable_hidden;
    logic                   enable_classi;
    logic                   hidden_in;
    logic                   hidden_pixel;
    logic                   spike_in;
    logic [N_CLS*CNT_W-1:0] class_count;
    logic [CLS_AW-1:0]      result;

    rbm_sequencer #(
        .N_VIS(N_VIS), .N_HID(N_HID), .N_CLS(N_CLS), .N_ITER(N_ITER),
        .VIS_AW(VIS_AW), .HID_AW(HID_AW), .CLS_AW(CLS_AW), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .vis_addr(vis_addr), .hid_addr(hid_addr), .cls_addr(cls_addr),
        .sel_bias(sel_bias), .pixel_in(pixel_in), .pixel(pixel),
        .enable_hidden(enable_hidden), .enable_classi(enable_classi),
        .hidden_in(hidden_in), .hidden_pixel(hidden_pixel), .spike_in(spike_in),
        .class_count(class_count), .result(result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N_CLS*CNT_W-1:0] cnt;
        logic [CLS_AW-1:0]      res;
        int                     done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_vis"}, vis_addr, 0);
        chk({tag, "_hid"}, hid_addr, 0);
        chk({tag, "_cls"}, cls_addr, 0);
        chk({tag, "_sel"}, sel_bias, 0);
        chk({tag, "_pix"}, pixel, 0);
        chk({tag, "_hpix"}, hidden_pixel, 0);
        chk({tag, "_en"}, {enable_hidden, enable_classi}, 0);
        chk({tag, "_cnt"}, class_count, 0);
        chk({tag, "_res"}, result, 0);
    endtask

    // Drive datapath inputs for run cycle c. Off-capture cycles carry
    // values opposite to/independent of the capture data so a capture
    // in the wrong cycle shows up in the results.
    task automatic drive_inputs(input int c, input logic [2:0] hb, input logic [1:0] sm);
        int k, n, j, m, cl;
        hidden_in = 1'b1;
        spike_in  = 1'b1;
        if (c >= 1 && c <= RUN_CYC) begin
            k = (c - 1) % ITER_CYC;
            if (k < HPH_CYC) begin
                n = k / NEU_CYC;
                j = k % NEU_CYC;
                hidden_in = (j == NEU_CYC - 1) ? hb[n] : ~hb[n];
            end else begin
                m  = k - HPH_CYC;
                cl = m / CLS_CYC;
                j  = m % CLS_CYC;
                spike_in = (j == CLS_CYC - 1) ? sm[cl] : 1'b1;
            end
        end
    endtask

    // Expected address/strobe pattern for run cycle c (1..RUN_CYC).
    task automatic check_cycle(input int c, input logic [2:0] hb);
        int k, n, j, m, cl;
        k = (c - 1) % ITER_CYC;
        chk("busy", busy, 1);
        chk("excl", enable_hidden & enable_classi, 0);
        if (k < HPH_CYC) begin
            n = k / NEU_CYC;
            j = k % NEU_CYC;
            chk("h_vis", vis_addr, (j <= N_VIS) ? j : N_VIS);
            chk("h_hid", hid_addr, n);
            chk("h_cls", cls_addr, 0);
            chk("h_sel", sel_bias, (j == N_VIS));
            chk("h_pix", pixel, (j <= N_VIS));
            chk("h_hpix", hidden_pixel, 0);
            chk("h_en", {enable_hidden, enable_classi}, 2'b10);
        end else begin
            m  = k - HPH_CYC;
            cl = m / CLS_CYC;
            j  = m % CLS_CYC;
            chk("c_hid", hid_addr, (j <= N_HID) ? j : N_HID);
            chk("c_cls", cls_addr, cl);
            chk("c_sel", sel_bias, (j == N_HID));
            chk("c_pix", pixel, 0);
            chk("c_hpix", hidden_pixel, (j < N_HID) ? hb[j] : (j == N_HID));
            chk("c_en", {enable_hidden, enable_classi}, 2'b01);
        end
    endtask

    // One inference. restart_at: cycle with a spurious start pulse (0 = none).
    // reset_at: cycle at which reset aborts the run (0 = run to completion).
    task automatic run_inf(input logic [2:0] hb, input logic [1:0] sm,
                           input int restart_at, input int reset_at,
                           input logic [N_CLS*CNT_W-1:0] ecnt, input logic [CLS_AW-1:0] eres);
        exp_t e;
        if (reset_at == 0) begin
            e.cnt = ecnt;
            e.res = eres;
            e.done_cyc = DONE_CYC;
            sb.push_back(e);
        end
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= DONE_CYC + 5; c++) begin
            @(negedge clock);
            start = (c == restart_at);
            drive_inputs(c, hb, sm);
            if (c <= RUN_CYC) begin
                check_cycle(c, hb);
            end else if (c < DONE_CYC) begin
                chk("am_busy", busy, 1);
                chk("am_en", {enable_hidden, enable_classi, sel_bias}, 0);
            end else if (c > DONE_CYC) begin
                chk("hold_busy", busy, 0);
                chk("hold_cnt", class_count, ecnt);
                chk("hold_res", result, eres);
            end
            chk("done_t", done, (c == DONE_CYC));
            if (done) begin
                chk("done_busy", busy, 0);
                if (sb.size() == 0) begin
                    chk("sb_empty_at_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cyc", c, e.done_cyc);
                    chk("count", class_count, e.cnt);
                    chk("result", result, e.res);
                end
            end
            if (reset_at != 0 && c == reset_at) begin
                reset = 1'b1;
                #1;
                chk_idle_zero("rst_mid");
                @(negedge clock);
                reset = 1'b0;
                start = 1'b0;
                for (int t = 0; t < DONE_CYC + 5; t++) begin
                    @(negedge clock);
                    chk("post_rst_quiet", {busy, done}, 0);
                end
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pixel_in  = 1'b1;
        hidden_in = 1'b0;
        spike_in  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_idle_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle_no_start", {busy, done}, 0);

        // Spikes only in class 1: class1=2, class0=0, argmax 1.
        run_inf(3'b101, 2'b10, 0, 0, 4'b1000, 1'b1);
        // Spikes everywhere: tie resolves to class 0; mid-run start ignored.
        run_inf(3'b011, 2'b11, 10, 0, 4'b1010, 1'b0);
        // Reset in the middle of the classifier phase aborts the run.
        run_inf(3'b101, 2'b11, 0, 20, 4'b0000, 1'b0);
        // Fresh run after abort: counts start from zero, class 0 wins.
        run_inf(3'b010, 2'b01, 0, 0, 4'b0010, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
